mem_tag_responder: RTL and testbench

Responder end of the processor–memory bus: accepts `BUS_LOAD` / `BUS_STORE` commands issued by the dcache/icache controllers and returns a transaction tag on `mem2proc_response` in the same cycle. Each load's 64-bit line is returned on `mem2proc_data` / `mem2proc_tag` exactly `MEM_LATENCY` cycles later. It backs a word-addressed storage array and serves as the synthesizable memory model for core-level simulation and FPGA bring-up.

---
 rtl/sys_defs.sv | 28 ++
 rtl/mem_tag_responder_if.sv | 26 ++
 rtl/mem_tag_alloc.sv | 48 ++++
 rtl/mem_tag_responder.sv | 111 +++++++++++
 tb/tb_mem_tag_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// Shared bus definitions for the processor-memory interface: command encoding,
// data width and the in-flight transaction record.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  localparam int DATA_SIZE = 64;

  // Storage width for tags inside the pipeline record; wide enough for any legal
  // NUM_MEM_TAGS below 256 so the record type does not depend on a parameter.
  localparam int TAG_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 is_load;
    logic [TAG_W-1:0]     tag;
    logic [DATA_SIZE-1:0] data;
  } inflight_t;

  function automatic int tag_width(input int num_tags);
    return $clog2(num_tags + 1);
  endfunction

endpackage

// File: rtl/mem_tag_responder_if.sv
// Processor-memory bus bundle: command/address/data toward memory, tagged
// response and load return toward the processor.
interface mem_tag_responder_if #(
  parameter int TW = 4
);
  import sys_defs::*;

  BUS_COMMAND           proc2mem_command;
  logic [31:0]          proc2mem_addr;
  logic [DATA_SIZE-1:0] proc2mem_data;
  logic [TW-1:0]        mem2proc_response;
  logic [DATA_SIZE-1:0] mem2proc_data;
  logic [TW-1:0]        mem2proc_tag;
  logic                 mem_err;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag, mem_err
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag, mem_err
  );

endinterface

// File: rtl/mem_tag_alloc.sv
// Tag pool: lowest-free priority encoder over a registered free bitmap.
// Bit i of the bitmap stands for tag i+1; tag 0 is never issued.
module mem_tag_alloc
  import sys_defs::*;
#(
  parameter int NUM_MEM_TAGS = 15,
  parameter int TW           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_alloc,
  input  logic [TAG_W-1:0] i_retire_tag,
  output logic [TW-1:0]    o_alloc_tag,
  output logic             o_any_free
);

  logic [NUM_MEM_TAGS-1:0] r_free;
  logic [NUM_MEM_TAGS-1:0] w_free_nxt;

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path through the block can leave it holding state (no latch).
  always_comb begin
    o_alloc_tag = '0;
    for (int i = NUM_MEM_TAGS - 1; i >= 0; i--) begin
      if (r_free[i]) o_alloc_tag = TW'(i + 1);
    end
  end

  assign o_any_free = |r_free;

  // Retire is applied after allocate: with a one-cycle latency the same tag
  // can be taken and returned on one edge, and it must end up free.
  always_comb begin
    w_free_nxt = r_free;
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      if (i_alloc && (o_alloc_tag == TW'(i + 1))) w_free_nxt[i] = 1'b0;
      if (i_retire_tag == TAG_W'(i + 1))          w_free_nxt[i] = 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_free <= '1;
    else        r_free <= w_free_nxt;
  end

endmodule

// File: rtl/mem_tag_responder.sv
// Tagged memory responder: same-cycle tag response, fixed-latency in-order load
// return, word-addressed array. Optional build macro: MEM_RESP_ALIGN_CHECK_EN.
module mem_tag_responder
  import sys_defs::*;
#(
  parameter int NUM_MEM_TAGS = 15,
  parameter int MEM_LATENCY  = 4,
  parameter int DEPTH        = 8192
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mem_tag_responder_if.slave   bus
);

  localparam int TW    = tag_width(NUM_MEM_TAGS);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  inflight_t            r_pipe [MEM_LATENCY];

  inflight_t            w_push;
  inflight_t            w_last;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_cmd_valid;
  logic                 w_addr_ok;
  logic                 w_any_free;
  logic                 w_accept;
  logic [TW-1:0]        w_alloc_tag;
  logic [TAG_W-1:0]     w_retire_tag;
  logic                 w_unused;

  assign w_idx       = bus.proc2mem_addr[3 +: IDX_W];
  assign w_cmd_valid = (bus.proc2mem_command != BUS_NONE);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic r_err;

  assign w_addr_ok = (bus.proc2mem_addr[2:0] == 3'b000);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     r_err <= 1'b0;
    else if (w_cmd_valid && !w_addr_ok) r_err <= 1'b1;
  end

  assign bus.mem_err = r_err;
`else
  assign w_addr_ok   = 1'b1;
  assign bus.mem_err = 1'b0;
`endif

  // Response depends only on the command (and alignment) and the tag bitmap.
  assign w_accept = reset_n && w_cmd_valid && w_addr_ok && w_any_free;
  assign bus.mem2proc_response = w_accept ? w_alloc_tag : '0;

  mem_tag_alloc #(
    .NUM_MEM_TAGS (NUM_MEM_TAGS),
    .TW           (TW)
  ) u_alloc (
    .clk          (clock),
    .rst_n        (reset_n),
    .i_alloc      (w_accept),
    .i_retire_tag (w_retire_tag),
    .o_alloc_tag  (w_alloc_tag),
    .o_any_free   (w_any_free)
  );

  // Load data is captured at accept, so later stores cannot alter it.
  always_comb begin
    w_push = '0;
    if (w_accept) begin
      w_push.valid   = 1'b1;
      w_push.is_load = (bus.proc2mem_command == BUS_LOAD);
      w_push.tag     = TAG_W'(w_alloc_tag);
      if (w_push.is_load) w_push.data = r_mem[w_idx];
    end
  end

  // NOTE: the storage array has no reset; clearing thousands of words is not
  // part of its behaviour and a reset would block RAM inference.
  always_ff @(posedge clock) begin
    if (w_accept && (bus.proc2mem_command == BUS_STORE)) begin
      r_mem[w_idx] <= bus.proc2mem_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MEM_LATENCY; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= w_push;
      for (int k = 1; k < MEM_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  // A tag is released on the edge its entry moves into the final stage, so it
  // is allocatable in the same cycle its load is presented on the bus.
  if (MEM_LATENCY == 1) begin : g_retire_lat1
    assign w_retire_tag = w_push.valid ? w_push.tag : '0;
  end else begin : g_retire_latn
    assign w_retire_tag = r_pipe[MEM_LATENCY-2].valid ? r_pipe[MEM_LATENCY-2].tag : '0;
  end

  assign w_last = r_pipe[MEM_LATENCY-1];

  assign bus.mem2proc_tag  = (w_last.valid && w_last.is_load) ? TW'(w_last.tag) : '0;
  assign bus.mem2proc_data = (w_last.valid && w_last.is_load) ? w_last.data : '0;

  // Offset bits, aliased upper address bits and spare tag storage bits.
  assign w_unused = ^{bus.proc2mem_addr, w_last.tag};

endmodule

// File: tb/tb_mem_tag_responder.sv
// Self-checking bench: two responders (15 tags/latency 4 and 3 tags/latency 6)
// driven with directed and random traffic against a cycle-indexed reference model.
module tb_mem_tag_responder;
  import sys_defs::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_tag_responder_if #(.TW(4)) bus_a ();
  mem_tag_responder_if #(.TW(2)) bus_b ();

  mem_tag_responder #(.NUM_MEM_TAGS(15), .MEM_LATENCY(4), .DEPTH(8192)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  mem_tag_responder #(.NUM_MEM_TAGS(3), .MEM_LATENCY(6), .DEPTH(8192)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Stimulus for the next cycle, one slot per DUT.
  BUS_COMMAND  cmd_q   [2];
  logic [31:0] addr_q  [2];
  logic [63:0] wdata_q [2];
  logic        rst_q;

  // Reference model: tag t is free from cycle busy_until[s][t] on; expected
  // returns are scheduled by absolute cycle (mod 64).
  int          busy_until [2][16];
  logic [63:0] mem_m      [2][8192];
  bit          known      [2][8192];
  int          exp_tag    [2][64];
  logic [63:0] exp_data   [2][64];
  bit          exp_dk     [2][64];
  bit          exp_err    [2];

  logic [63:0] obs_resp [2];
  logic [63:0] obs_tag  [2];
  logic [63:0] obs_data [2];
  logic [63:0] obs_err  [2];

  int          exp_ex [5] = '{1, 2, 3, 0, 0};
  logic [63:0] resp_hist [24];
  logic [63:0] tag_hist  [24];
  int          rejects;

  function automatic int lat(input int s);
    return (s == 0) ? 4 : 6;
  endfunction

  function automatic int ntags(input int s);
    return (s == 0) ? 15 : 3;
  endfunction

  function automatic bit aligned(input logic [31:0] a);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    return (a[2:0] == 3'b000);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    int slot;
    int mresp;
    int idx;
    int ret;
    @(negedge clock);
    reset_n = rst_q;
    bus_a.proc2mem_command = cmd_q[0];
    bus_a.proc2mem_addr    = addr_q[0];
    bus_a.proc2mem_data    = wdata_q[0];
    bus_b.proc2mem_command = cmd_q[1];
    bus_b.proc2mem_addr    = addr_q[1];
    bus_b.proc2mem_data    = wdata_q[1];
    #1;
    obs_resp[0] = 64'(bus_a.mem2proc_response);
    obs_tag[0]  = 64'(bus_a.mem2proc_tag);
    obs_data[0] = bus_a.mem2proc_data;
    obs_err[0]  = 64'(bus_a.mem_err);
    obs_resp[1] = 64'(bus_b.mem2proc_response);
    obs_tag[1]  = 64'(bus_b.mem2proc_tag);
    obs_data[1] = bus_b.mem2proc_data;
    obs_err[1]  = 64'(bus_b.mem_err);
    slot = cyc % 64;
    for (int s = 0; s < 2; s++) begin
      mresp = 0;
      if (rst_q && (cmd_q[s] != BUS_NONE) && aligned(addr_q[s])) begin
        for (int t = 1; t <= ntags(s); t++) begin
          if ((mresp == 0) && (busy_until[s][t] <= cyc)) mresp = t;
        end
      end
      ret = rst_q ? exp_tag[s][slot] : 0;
      check($sformatf("resp[%0d]@%0d", s, cyc), obs_resp[s], 64'(mresp));
      check($sformatf("tag[%0d]@%0d", s, cyc), obs_tag[s], 64'(ret));
      if (!rst_q)
        check($sformatf("rst_data[%0d]@%0d", s, cyc), obs_data[s], 64'd0);
      else if ((ret != 0) && exp_dk[s][slot])
        check($sformatf("data[%0d]@%0d", s, cyc), obs_data[s], exp_data[s][slot]);
      check($sformatf("err[%0d]@%0d", s, cyc), obs_err[s], 64'(rst_q ? exp_err[s] : 1'b0));
      exp_tag[s][slot] = 0;
      if (!rst_q) begin
        for (int t = 0; t < 16; t++) busy_until[s][t] = 0;
        for (int k = 0; k < 64; k++) exp_tag[s][k] = 0;
        exp_err[s] = 1'b0;
      end else begin
        if ((cmd_q[s] != BUS_NONE) && !aligned(addr_q[s])) exp_err[s] = 1'b1;
        if (mresp != 0) begin
          busy_until[s][mresp] = cyc + lat(s);
          idx = int'((addr_q[s] >> 3) % 8192);
          if (cmd_q[s] == BUS_LOAD) begin
            exp_tag[s][(cyc + lat(s)) % 64]  = mresp;
            exp_data[s][(cyc + lat(s)) % 64] = mem_m[s][idx];
            exp_dk[s][(cyc + lat(s)) % 64]   = known[s][idx];
          end else begin
            mem_m[s][idx] = wdata_q[s];
            known[s][idx] = 1'b1;
          end
        end
      end
    end
    @(posedge clock);
    cyc++;
    for (int s = 0; s < 2; s++) cmd_q[s] = BUS_NONE;
  endtask

  task automatic issue(input int s, input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] d);
    cmd_q[s]   = c;
    addr_q[s]  = a;
    wdata_q[s] = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      cmd_q[s] = BUS_NONE; addr_q[s] = '0; wdata_q[s] = '0; exp_err[s] = 1'b0;
      for (int t = 0; t < 16; t++) busy_until[s][t] = 0;
      for (int k = 0; k < 64; k++) begin exp_tag[s][k] = 0; exp_dk[s][k] = 1'b0; end
    end

    // Reset state
    rst_q = 1'b0;
    idle(2);
    check("reset_tag", obs_tag[0], 64'd0);
    check("reset_data", obs_data[0], 64'd0);
    check("reset_err", obs_err[0], 64'd0);
    rst_q = 1'b1;
    idle(1);

    // Preload array[0x10] then single load at 0x80
    issue(0, BUS_STORE, 32'h80, 64'hDEAD_BEEF_0123_4567);
    idle(5);
    issue(0, BUS_LOAD, 32'h80, '0);
    check("single_resp", obs_resp[0], 64'd1);
    idle(4);
    check("single_tag", obs_tag[0], 64'd1);
    check("single_data", obs_data[0], 64'hDEAD_BEEF_0123_4567);

    // Store then load, same index, consecutive cycles
    issue(0, BUS_STORE, 32'h100, 64'h1);
    check("hazard_store_resp", obs_resp[0], 64'd1);
    issue(0, BUS_LOAD, 32'h100, '0);
    check("hazard_load_resp", obs_resp[0], 64'd2);
    idle(4);
    check("hazard_tag", obs_tag[0], 64'd2);
    check("hazard_data", obs_data[0], 64'h1);

    // Tag exhaustion on the 3-tag / latency-6 instance
    issue(1, BUS_STORE, 32'h200, 64'hB0B0_1234_5678_9ABC);
    idle(7);
    for (int i = 0; i < 5; i++) begin
      issue(1, BUS_LOAD, 32'h200, '0);
      check($sformatf("exhaust_resp%0d", i), obs_resp[1], 64'(exp_ex[i]));
    end
    idle(1);
    issue(1, BUS_LOAD, 32'h200, '0);
    check("exhaust_retry", obs_resp[1], 64'd1);
    idle(8);

    // Reset while loads are in flight
    issue(0, BUS_LOAD, 32'h80, '0);
    issue(0, BUS_LOAD, 32'h80, '0);
    rst_q = 1'b0;
    idle(1);
    rst_q = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("post_reset_tag", obs_tag[0], 64'd0);
    end
    issue(0, BUS_LOAD, 32'h80, '0);
    check("post_reset_resp", obs_resp[0], 64'd1);
    idle(4);

    // Misaligned load
    issue(0, BUS_LOAD, 32'h84, '0);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    check("misalign_resp", obs_resp[0], 64'd0);
    idle(3);
    check("misalign_err_sticky", obs_err[0], 64'd1);
`else
    check("misalign_resp", obs_resp[0], 64'd1);
    idle(4);
    check("misalign_tag", obs_tag[0], 64'd1);
    check("misalign_data", obs_data[0], 64'hDEAD_BEEF_0123_4567);
`endif
    idle(5);

    // Streaming: preload 16 words, then 20 back-to-back aliased loads
    for (int i = 0; i < 16; i++)
      issue(0, BUS_STORE, 32'((32'h40 + i) << 3), {$urandom, $urandom});
    idle(5);
    rejects = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 20)
        issue(0, BUS_LOAD, ($urandom & 32'hFFFF_0000) | 32'((32'h40 + (k % 16)) << 3), '0);
      else
        idle(1);
      resp_hist[k] = obs_resp[0];
      tag_hist[k]  = obs_tag[0];
      if ((k < 20) && (obs_resp[0] == 64'd0)) rejects++;
    end
    check("stream_rejects", 64'(rejects), 64'd0);
    for (int k = 0; k < 24; k++)
      check($sformatf("stream_order%0d", k), tag_hist[k], (k >= 4) ? resp_hist[k-4] : 64'd0);

    // Random mixed traffic on both instances
    for (int n = 0; n < 300; n++) begin
      for (int s = 0; s < 2; s++) begin
        cmd_q[s]   = BUS_COMMAND'($urandom_range(0, 2));
        addr_q[s]  = ($urandom & 32'hFFFF_0000) | 32'((32'h40 + $urandom_range(0, 15)) << 3);
        if ($urandom_range(0, 7) == 0) addr_q[s][2:0] = 3'($urandom_range(1, 7));
        wdata_q[s] = {$urandom, $urandom};
      end
      tick();
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
